// File: rtl/wb_commit_stage.sv
// ============================================================================
// wb_commit_stage : write-back / commit stage of the five-stage in-order pipe.
// Revision 1.0    : parameterised successor of the fixed 32-bit WB stage.
// ============================================================================
`default_nettype none

module wb_commit_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int ECODE_W = 6,
  parameter int CNT_W   = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ms_to_ws_valid,
  input  logic [2+ECODE_W+1+5+DATA_W+PC_W-1:0]   ms_to_ws_bus,
  output logic                                   ws_allowin,
  input  logic                                   ws_stall,
  output logic [6+DATA_W-1:0]                    ws_to_rf_bus,
  output logic [6+DATA_W:0]                      ws_to_ds_bus,
  output logic                                   ws_flush,
  output logic                                   ws_flush_ertn,
  output logic [ECODE_W-1:0]                     ws_ex_ecode,
  output logic [PC_W-1:0]                        ws_ex_pc,
  output logic [CNT_W-1:0]                       ws_instret,
  output logic [PC_W-1:0]                        debug_wb_pc,
  output logic [DATA_W/8-1:0]                    debug_wb_rf_we,
  output logic [4:0]                             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                      debug_wb_rf_wdata
);

  localparam int MS_W = 2 + ECODE_W + 1 + 5 + DATA_W + PC_W;

  logic              ws_valid_q, ws_valid_d;
  logic [MS_W-1:0]   bus_q, bus_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic               f_ex, f_ertn, f_gr_we;
  logic [ECODE_W-1:0] f_ecode;
  logic [4:0]         f_dest;
  logic [DATA_W-1:0]  f_result;
  logic [PC_W-1:0]    f_pc;

  logic ws_ready_go, ws_commit, rf_we;

  assign f_pc     = bus_q[PC_W-1:0];
  assign f_result = bus_q[PC_W +: DATA_W];
  assign f_dest   = bus_q[PC_W+DATA_W +: 5];
  assign f_gr_we  = bus_q[PC_W+DATA_W+5];
  assign f_ecode  = bus_q[PC_W+DATA_W+6 +: ECODE_W];
  assign f_ertn   = bus_q[MS_W-2];
  assign f_ex     = bus_q[MS_W-1];

  // Commit is suppressed in a reset cycle so a held instruction never writes.
  assign ws_ready_go = ~ws_stall;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  assign ws_commit   = ws_valid_q & ws_ready_go & ~reset;

  assign ws_flush      = ws_commit & (f_ex | f_ertn);
  assign ws_flush_ertn = ws_commit & f_ertn & ~f_ex;
  assign rf_we         = ws_commit & ~f_ex & ~f_ertn & f_gr_we & (f_dest != 5'd0);
  assign ws_ex_ecode   = ws_flush ? f_ecode : '0;
  assign ws_ex_pc      = ws_flush ? f_pc : '0;

  assign ws_to_rf_bus = {rf_we, f_dest, f_result};
  // Forwarding view ignores the stall so decode sees a write that is pending.
  assign ws_to_ds_bus = {ws_valid_q, ws_valid_q & f_gr_we & ~f_ex & ~f_ertn,
                         f_dest, f_result};
  assign ws_instret   = instret_q;

  assign debug_wb_pc       = f_pc;
  assign debug_wb_rf_we    = {(DATA_W/8){rf_we}};
  assign debug_wb_rf_wnum  = f_dest;
  assign debug_wb_rf_wdata = f_result;

  always_comb begin
    ws_valid_d = ws_valid_q;
    bus_d      = bus_q;
    instret_d  = instret_q;
    if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid & ~ws_flush;
    end
    if (ms_to_ws_valid && ws_allowin) begin
      bus_d = ms_to_ws_bus;
    end
    if (ws_commit && !f_ex) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
      instret_q  <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
      instret_q  <= instret_d;
    end
  end

endmodule

`default_nettype wire
